// File: rtl/safe_pkg.sv
// Shared types and constants for the safe lock controller and the
// VGA pattern generator that consumes pattern_sel.
package safe_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      LK_CLOSED  = 2'b00,
      LK_OPEN    = 2'b01,
      LK_LOCKOUT = 2'b10,
      LK_ALARM   = 2'b11
   } lk_state_e;

   // Pattern select codes understood by pattern_gen.
   localparam logic [1:0] PAT_IDLE  = 2'b00;
   localparam logic [1:0] PAT_GREEN = 2'b01;
   localparam logic [1:0] PAT_RED   = 2'b10;

   // Map a controller state onto the pattern shown on the display.
   function automatic logic [1:0] pattern_for(input lk_state_e st);
      logic [1:0] pat;
      case (st)
         LK_OPEN:    pat = PAT_GREEN;
         LK_LOCKOUT: pat = PAT_RED;
         LK_ALARM:   pat = PAT_RED;
         default:    pat = PAT_IDLE;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/safe_lock_ctrl_if.sv
// Password-check handshake between the entry/compare front end (master)
// and the lock controller (slave).
interface safe_lock_ctrl_if;

   logic check_valid;
   logic check_match;
   logic check_ack;
   logic check_rej;

   modport master (
      output check_valid,
      output check_match,
      input  check_ack,
      input  check_rej
   );

   modport slave (
      input  check_valid,
      input  check_match,
      output check_ack,
      output check_rej
   );

endinterface

// File: rtl/sec_timer.sv
// Seconds down-counter driven by a tick prescaler. A load restarts the
// prescaler and sets the seconds value; expire flags the wrap that takes
// the count from 1 to 0.
module sec_timer #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       en,
   output logic [7:0] sec_left,
   output logic       expire
);

   localparam logic [7:0] TICK_MAX = 8'(TICKS_PER_SEC - 1);

   logic [7:0] presc_r;
   logic [7:0] sec_left_r;
   logic       wrap_s;

   assign wrap_s   = en && (presc_r == TICK_MAX);
   assign expire   = wrap_s && (sec_left_r == 8'd1);
   assign sec_left = sec_left_r;

   // Prescaler and seconds counter; load has priority over counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r    <= 8'd0;
         sec_left_r <= 8'd0;
      end else if (load) begin
         presc_r    <= 8'd0;
         sec_left_r <= load_val;
      end else if (wrap_s) begin
         presc_r <= 8'd0;
         if (sec_left_r != 8'd0) begin
            sec_left_r <= sec_left_r - 8'd1;
         end else begin
            sec_left_r <= sec_left_r;
         end
      end else if (en) begin
         presc_r <= presc_r + 8'd1;
      end else begin
         presc_r <= presc_r;
      end
   end

endmodule

// File: rtl/safe_lock_ctrl.sv
// Responder side of the password-check handshake: consumes check results,
// acknowledges or refuses them, and runs the CLOSED/OPEN/LOCKOUT/ALARM
// policy with timed unlock and lockout windows.
module safe_lock_ctrl
   import safe_pkg::*;
#(
   parameter int MAX_FAIL      = 3,
   parameter int UNLOCK_SEC    = 5,
   parameter int LOCKOUT_SEC   = 10,
   parameter int MAX_LOCKOUT   = 2,
   parameter int TICKS_PER_SEC = 100
) (
   input  logic                   clk,
   input  logic                   rst,
   safe_lock_ctrl_if.slave        chk,
   input  logic                   relock,
   input  logic                   alarm_clr,
   output logic                   unlocked,
   output logic                   lockout,
   output logic                   alarm,
   output logic [2:0]             fail_cnt,
   output logic [7:0]             sec_left,
   output logic [1:0]             pattern_sel
);

   localparam logic [2:0] FAIL_LIMIT = 3'(MAX_FAIL);
   localparam logic [1:0] LK_LIMIT   = 2'(MAX_LOCKOUT);
   localparam logic [7:0] OPEN_SECS  = 8'(UNLOCK_SEC);
   localparam logic [7:0] LOCK_SECS  = 8'(LOCKOUT_SEC);

   lk_state_e  state_r;
   lk_state_e  next_state_s;
   logic [2:0] fail_cnt_r;
   logic [2:0] fail_next_s;
   logic [1:0] lk_cnt_r;
   logic [1:0] lk_next_s;
   logic       ack_r;
   logic       rej_r;
   logic       ack_next_s;
   logic       rej_next_s;
   logic       unlocked_r;
   logic       lockout_r;
   logic       alarm_r;
   logic [1:0] pattern_sel_r;

   logic       req_s;
   logic       tmr_load_s;
   logic [7:0] tmr_load_val_s;
   logic       tmr_en_s;
   logic       tmr_expire_s;
   logic [7:0] tmr_sec_left_s;

   // A held valid is not taken again in the cycle right after a response.
   assign req_s    = chk.check_valid && !(ack_r || rej_r);
   assign tmr_en_s = (state_r == LK_OPEN) || (state_r == LK_LOCKOUT);

   sec_timer #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_sec_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load_s),
      .load_val (tmr_load_val_s),
      .en       (tmr_en_s),
      .sec_left (tmr_sec_left_s),
      .expire   (tmr_expire_s)
   );

   // Next-state, counter updates, handshake response and timer loads.
   always_comb begin
      next_state_s   = state_r;
      fail_next_s    = fail_cnt_r;
      lk_next_s      = lk_cnt_r;
      ack_next_s     = 1'b0;
      rej_next_s     = 1'b0;
      tmr_load_s     = 1'b0;
      tmr_load_val_s = 8'd0;
      case (state_r)
         LK_CLOSED: begin
            if (req_s) begin
               ack_next_s = 1'b1;
               if (chk.check_match) begin
                  next_state_s   = LK_OPEN;
                  fail_next_s    = 3'd0;
                  lk_next_s      = 2'd0;
                  tmr_load_s     = 1'b1;
                  tmr_load_val_s = OPEN_SECS;
               end else if ((fail_cnt_r + 3'd1) == FAIL_LIMIT) begin
                  fail_next_s = 3'd0;
                  lk_next_s   = lk_cnt_r + 2'd1;
                  tmr_load_s  = 1'b1;
                  if ((lk_cnt_r + 2'd1) == LK_LIMIT) begin
                     next_state_s   = LK_ALARM;
                     tmr_load_val_s = 8'd0;
                  end else begin
                     next_state_s   = LK_LOCKOUT;
                     tmr_load_val_s = LOCK_SECS;
                  end
               end else begin
                  fail_next_s = fail_cnt_r + 3'd1;
               end
            end else begin
               next_state_s = LK_CLOSED;
            end
         end
         LK_OPEN: begin
            ack_next_s = req_s;
            if (relock || tmr_expire_s) begin
               next_state_s = LK_CLOSED;
               tmr_load_s   = 1'b1;
            end else begin
               next_state_s = LK_OPEN;
            end
         end
         LK_LOCKOUT: begin
            rej_next_s = req_s;
            if (tmr_expire_s) begin
               next_state_s = LK_CLOSED;
               tmr_load_s   = 1'b1;
            end else begin
               next_state_s = LK_LOCKOUT;
            end
         end
         LK_ALARM: begin
            rej_next_s = req_s;
            if (alarm_clr) begin
               next_state_s = LK_CLOSED;
               lk_next_s    = 2'd0;
               fail_next_s  = 3'd0;
               tmr_load_s   = 1'b1;
            end else begin
               next_state_s = LK_ALARM;
            end
         end
         default: begin
            next_state_s = LK_CLOSED;
            fail_next_s  = 3'd0;
            lk_next_s    = 2'd0;
            tmr_load_s   = 1'b1;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= LK_CLOSED;
         fail_cnt_r    <= 3'd0;
         lk_cnt_r      <= 2'd0;
         ack_r         <= 1'b0;
         rej_r         <= 1'b0;
         unlocked_r    <= 1'b0;
         lockout_r     <= 1'b0;
         alarm_r       <= 1'b0;
         pattern_sel_r <= PAT_IDLE;
      end else begin
         state_r       <= next_state_s;
         fail_cnt_r    <= fail_next_s;
         lk_cnt_r      <= lk_next_s;
         ack_r         <= ack_next_s;
         rej_r         <= rej_next_s;
         unlocked_r    <= (next_state_s == LK_OPEN);
         lockout_r     <= (next_state_s == LK_LOCKOUT);
         alarm_r       <= (next_state_s == LK_ALARM);
         pattern_sel_r <= pattern_for(next_state_s);
      end
   end

   assign chk.check_ack = ack_r;
   assign chk.check_rej = rej_r;
   assign unlocked      = unlocked_r;
   assign lockout       = lockout_r;
   assign alarm         = alarm_r;
   assign fail_cnt      = fail_cnt_r;
   assign sec_left      = tmr_sec_left_s;
   assign pattern_sel   = pattern_sel_r;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Bench for safe_lock_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model that tracks the open and
// lockout windows as a plain count of remaining clock cycles.
module tb_safe_lock_ctrl;

   localparam int MAX_FAIL    = 3;
   localparam int UNLOCK_SEC  = 5;
   localparam int LOCKOUT_SEC = 10;
   localparam int MAX_LOCKOUT = 2;
   localparam int TPS         = 100;

   localparam int M_CLOSED  = 0;
   localparam int M_OPEN    = 1;
   localparam int M_LOCKOUT = 2;
   localparam int M_ALARM   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       relock;
   logic       alarm_clr;
   logic       unlocked;
   logic       lockout;
   logic       alarm;
   logic [2:0] fail_cnt;
   logic [7:0] sec_left;
   logic [1:0] pattern_sel;

   safe_lock_ctrl_if chk_bus ();

   safe_lock_ctrl #(
      .MAX_FAIL      (MAX_FAIL),
      .UNLOCK_SEC    (UNLOCK_SEC),
      .LOCKOUT_SEC   (LOCKOUT_SEC),
      .MAX_LOCKOUT   (MAX_LOCKOUT),
      .TICKS_PER_SEC (TPS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .chk         (chk_bus),
      .relock      (relock),
      .alarm_clr   (alarm_clr),
      .unlocked    (unlocked),
      .lockout     (lockout),
      .alarm       (alarm),
      .fail_cnt    (fail_cnt),
      .sec_left    (sec_left),
      .pattern_sel (pattern_sel)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model state.
   int m_mode   = M_CLOSED;
   int m_fail   = 0;
   int m_lk     = 0;
   int m_cycles = 0;
   int m_ack    = 0;
   int m_rej    = 0;

   task automatic check_value(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_edge();
      bit req;
      if (rst) begin
         m_mode = M_CLOSED; m_fail = 0; m_lk = 0; m_cycles = 0;
         m_ack = 0; m_rej = 0;
         return;
      end
      req   = chk_bus.check_valid && !(m_ack != 0 || m_rej != 0);
      m_ack = 0;
      m_rej = 0;
      case (m_mode)
         M_CLOSED: if (req) begin
            m_ack = 1;
            if (chk_bus.check_match) begin
               m_mode = M_OPEN; m_fail = 0; m_lk = 0;
               m_cycles = UNLOCK_SEC * TPS;
            end else begin
               m_fail++;
               if (m_fail == MAX_FAIL) begin
                  m_fail = 0;
                  m_lk++;
                  if (m_lk == MAX_LOCKOUT) begin
                     m_mode = M_ALARM; m_cycles = 0;
                  end else begin
                     m_mode = M_LOCKOUT; m_cycles = LOCKOUT_SEC * TPS;
                  end
               end
            end
         end
         M_OPEN: begin
            if (req) m_ack = 1;
            m_cycles--;
            if (relock || m_cycles == 0) begin
               m_mode = M_CLOSED; m_cycles = 0;
            end
         end
         M_LOCKOUT: begin
            if (req) m_rej = 1;
            m_cycles--;
            if (m_cycles == 0) m_mode = M_CLOSED;
         end
         default: begin
            if (req) m_rej = 1;
            if (alarm_clr) begin
               m_mode = M_CLOSED; m_lk = 0; m_fail = 0;
            end
         end
      endcase
   endtask

   task automatic compare_all();
      int exp_pat;
      exp_pat = (m_mode == M_OPEN) ? 1 : ((m_mode == M_CLOSED) ? 0 : 2);
      check_value("check_ack", int'(chk_bus.check_ack), m_ack);
      check_value("check_rej", int'(chk_bus.check_rej), m_rej);
      check_value("unlocked", int'(unlocked), int'(m_mode == M_OPEN));
      check_value("lockout", int'(lockout), int'(m_mode == M_LOCKOUT));
      check_value("alarm", int'(alarm), int'(m_mode == M_ALARM));
      check_value("fail_cnt", int'(fail_cnt), m_fail);
      check_value("sec_left", int'(sec_left), (m_cycles + TPS - 1) / TPS);
      check_value("pattern_sel", int'(pattern_sel), exp_pat);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Present one check result and hold it until answered (bounded).
   task automatic send(input logic match, output int resp);
      chk_bus.check_valid = 1'b1;
      chk_bus.check_match = match;
      resp = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (chk_bus.check_ack) begin resp = 1; break; end
         if (chk_bus.check_rej) begin resp = 2; break; end
      end
      chk_bus.check_valid = 1'b0;
      chk_bus.check_match = 1'b0;
      if (resp == 0) check_value("resp_timeout", 0, 1);
   endtask

   task automatic pulse_relock();
      relock = 1'b1; tick(); relock = 1'b0;
   endtask

   initial begin
      int r;
      int n_ack;
      rst = 1'b1; relock = 1'b0; alarm_clr = 1'b0;
      chk_bus.check_valid = 1'b0; chk_bus.check_match = 1'b0;
      idle(2);
      check_value("rst_unlocked", int'(unlocked), 0);
      check_value("rst_pattern", int'(pattern_sel), 0);
      rst = 1'b0;
      tick();

      // 1: correct password, auto relock after UNLOCK_SEC seconds.
      send(1'b1, r);
      check_value("t1_resp", r, 1);
      check_value("t1_sec", int'(sec_left), 5);
      check_value("t1_pat", int'(pattern_sel), 1);
      idle(499);
      check_value("t1_still_open", int'(unlocked), 1);
      tick();
      check_value("t1_closed", int'(unlocked), 0);

      // 2: three failures -> lockout, rejection, timeout.
      send(1'b0, r); check_value("t2_fail1", int'(fail_cnt), 1);
      send(1'b0, r); check_value("t2_fail2", int'(fail_cnt), 2);
      send(1'b0, r);
      check_value("t2_lockout", int'(lockout), 1);
      check_value("t2_sec", int'(sec_left), 10);
      send(1'b1, r); check_value("t2_rej", r, 2);
      idle(1000);
      check_value("t2_released", int'(lockout), 0);
      check_value("t2_fail0", int'(fail_cnt), 0);

      // 3: second failure window -> alarm, clear, third window -> lockout.
      for (int i = 0; i < 3; i++) send(1'b0, r);
      check_value("t3_alarm", int'(alarm), 1);
      send(1'b1, r); check_value("t3_rej", r, 2);
      idle(2000);
      check_value("t3_alarm_held", int'(alarm), 1);
      alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
      check_value("t3_cleared", int'(alarm), 0);
      for (int i = 0; i < 3; i++) send(1'b0, r);
      check_value("t3_lockout_not_alarm", int'(lockout), 1);
      idle(1000);

      // 4: early relock, relock while closed.
      send(1'b1, r);
      idle(100);
      check_value("t4_sec4", int'(sec_left), 4);
      pulse_relock();
      check_value("t4_relocked", int'(unlocked), 0);
      check_value("t4_sec0", int'(sec_left), 0);
      pulse_relock();
      check_value("t4_closed_pat", int'(pattern_sel), 0);

      // 5: success clears the failure window.
      send(1'b0, r); send(1'b0, r);
      send(1'b1, r);
      check_value("t5_fail_clr", int'(fail_cnt), 0);
      pulse_relock();
      send(1'b0, r); send(1'b0, r);
      check_value("t5_no_lockout", int'(lockout), 0);

      // 6: reset in lockout with valid held across it.
      send(1'b0, r);
      check_value("t6_lockout", int'(lockout), 1);
      idle(300);
      check_value("t6_sec7", int'(sec_left), 7);
      chk_bus.check_valid = 1'b1; chk_bus.check_match = 1'b1;
      rst = 1'b1; tick(); rst = 1'b0;
      check_value("t6_rst_lockout", int'(lockout), 0);
      check_value("t6_rst_sec", int'(sec_left), 0);
      n_ack = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (chk_bus.check_ack) begin
            if (i == 0) n_ack += 0;
            n_ack++;
            chk_bus.check_valid = 1'b0;
         end
      end
      check_value("t6_single_ack", n_ack, 1);
      chk_bus.check_valid = 1'b0; chk_bus.check_match = 1'b0;

      // Random traffic against the model.
      for (int c = 0; c < 20000; c++) begin
         rst       = ($urandom_range(0, 511) == 0);
         relock    = ($urandom_range(0, 63) == 0);
         alarm_clr = ($urandom_range(0, 63) == 0);
         if (chk_bus.check_valid) begin
            if ((chk_bus.check_ack || chk_bus.check_rej) && $urandom_range(0, 3) != 0)
               chk_bus.check_valid = 1'b0;
         end else if ($urandom_range(0, 7) == 0) begin
            chk_bus.check_valid = 1'b1;
            chk_bus.check_match = ($urandom_range(0, 3) == 0);
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/safe_lock_ctrl.md
Name: safe_lock_ctrl

Overview:
Responder side of the password-check handshake. Consumes one check result per request from the password entry/compare front end, acknowledges it, and decides whether the safe is unlocked, closed, locked out after repeated failures, or in alarm. Runs on the 100 Hz system tick clock. Drives the 2-bit pattern select for the VGA pattern generator, plus status LEDs.

Parameters:
MAX_FAIL, 3, consecutive wrong checks that trigger a lockout (1..7)
UNLOCK_SEC, 5, seconds the safe stays open before auto-relock (1..255)
LOCKOUT_SEC, 10, lockout duration in seconds (1..255)
MAX_LOCKOUT, 2, lockouts without an intervening success that escalate to alarm (1..3)
TICKS_PER_SEC, 100, clk cycles per second (2..255)

Ports:
clk  in  1  system clock (100 Hz tick domain)
rst  in  1  synchronous, active-high reset
check_valid  in  1  check result presented; held high until check_ack or check_rej
check_match  in  1  1 = password correct; qualified by check_valid
relock  in  1  debounced pulse; closes the safe early
alarm_clr  in  1  debounced pulse; clears the alarm
check_ack  out  1  one-cycle pulse: result consumed
check_rej  out  1  one-cycle pulse: result refused (LOCKOUT or ALARM)
unlocked  out  1  high in OPEN
lockout  out  1  high in LOCKOUT
alarm  out  1  high in ALARM
fail_cnt  out  3  consecutive failures in the current window
sec_left  out  8  remaining seconds in OPEN/LOCKOUT; 0 otherwise
pattern_sel  out  2  00 idle/closed, 01 green (OPEN), 10 red (LOCKOUT/ALARM)

Behaviour:
- Reset values: state CLOSED, all outputs 0, internal lockout counter lk_cnt = 0, prescaler = 0.
- Handshake rules:
  - A request is recognised when check_valid=1 and no ack/rej was issued in the previous cycle. This prevents double-consume while the requester drops valid.
  - The response pulse appears on the same clock edge that updates state, giving 1-cycle latency from valid to ack/rej.
  - check_ack and check_rej are never high together.
- Second prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in OPEN/LOCKOUT. It clears on every entry into those states.
  - On wrap, sec_left decrements. Transition happens on the wrap where sec_left==1, so sec_left reads 0 for the cycle after exit.
- States and transitions:
  - CLOSED: valid & match -> OPEN, ack, fail_cnt<=0, lk_cnt<=0, sec_left<=UNLOCK_SEC.
  - CLOSED: valid & !match -> ack, fail_cnt+1. If the new count == MAX_FAIL -> LOCKOUT, fail_cnt<=0, lk_cnt+1, sec_left<=LOCKOUT_SEC. If that lk_cnt+1 == MAX_LOCKOUT -> ALARM instead, with sec_left 0.
  - OPEN: valid (either value) -> ack, no state change (re-entry extends nothing).
  - OPEN: relock or timeout -> CLOSED. Relock takes effect the next edge.
  - LOCKOUT: valid -> rej; fail_cnt unchanged. Timeout -> CLOSED.
  - ALARM: valid -> rej. alarm_clr -> CLOSED, lk_cnt<=0, fail_cnt<=0. Only rst or alarm_clr leave ALARM.
- Simultaneous events:
  - relock and valid in the same cycle in OPEN: ack issued and state -> CLOSED.
  - alarm_clr outside ALARM: ignored.
  - relock outside OPEN: ignored.
- Counter widths: fail_cnt saturates by construction (never exceeds MAX_FAIL-1 when observed). lk_cnt is 2 bits.
- Reset mid-operation (e.g. in OPEN with sec_left=3): next edge all outputs return to reset values. A pending check_valid is then treated as a fresh request one cycle after rst deasserts.
- Outputs are registered (pattern_sel decoded from the registered state is acceptable if glitch-free, i.e. state is a register).

Decomposition:
- Shared package safe_pkg holds:
  - state encoding constants: LK_CLOSED, LK_OPEN, LK_LOCKOUT, LK_ALARM;
  - pattern-select constants: PAT_IDLE=2'b00, PAT_GREEN=2'b01, PAT_RED=2'b10, reused by the top and pattern_gen.
- One sub-module, sec_timer:
  - prescaler plus 8-bit down-counter;
  - inputs load, load_val, en;
  - outputs sec_left, expire (one-cycle pulse on final wrap).

Test Plan:
1. Reset, then valid=1/match=1 -> ack at +1 cycle, unlocked=1, pattern_sel=01, sec_left=5. After 500 cycles unlocked=0, pattern_sel=00.
2. Three mismatches (valid held until ack each time) -> fail_cnt 1,2, then lockout=1, sec_left=10, pattern_sel=10. A valid during lockout gives check_rej, not ack. After 1000 cycles -> CLOSED, fail_cnt=0.
3. Second full failure window without a success -> alarm=1. valid -> rej. After 2000 idle cycles still alarm. alarm_clr -> CLOSED, lk_cnt cleared (a third failure window yields LOCKOUT, not ALARM).
4. OPEN with sec_left=4, relock pulse -> unlocked=0 next edge, sec_left=0. Relock in CLOSED -> no change.
5. Two mismatches then a match -> fail_cnt returns to 0. A further two mismatches do not lock out.
6. In LOCKOUT with sec_left=7, assert rst one cycle -> all outputs 0. check_valid held across rst -> single ack one cycle after rst release, never two.
